seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. Holds eight {dp,hex} digit registers and scans
// them one slot at a time, with all-off blanking gaps between slots.
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_OFF    | scan disabled; all outputs dark, idx and cnt held at 0
//   S_ACTIVE | digit idx driven for DIV cycles (cnt counts 0..DIV-1)
//   S_DEAD   | all-off gap of DEAD cycles before advancing to idx+1
module seg_scan_ctrl #(
  parameter int DIV  = 1000,
  parameter int DEAD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [4:0] wr_data,
  input  logic [7:0] blank,
  output logic [7:0] seg_out,
  output logic [7:0] an_out,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_ACTIVE = 2'd1,
    S_DEAD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick_q, tick_d;
  logic [4:0]    digit_q [8];
  logic [7:0]    blank_q;
  logic [4:0]    cur_digit;
  logic [6:0]    pattern;

  // Next-state logic; en low overrides everything and parks the scan in OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          idx_d   = '0;
        end
        S_ACTIVE: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_DEAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = S_ACTIVE;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            tick_d  = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Scan state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  // Digit registers and blank mask; blank is registered so no input reaches
  // an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      blank_q <= '0;
    end else begin
      if (wr_en) digit_q[wr_idx] <= wr_data;
      blank_q <= blank;
    end
  end

  // Hex to active-high {a..g} pattern for the digit currently selected.
  always_comb begin
    cur_digit = digit_q[idx_q];
    case (cur_digit[3:0])
      4'h0: pattern = 7'h7E;
      4'h1: pattern = 7'h30;
      4'h2: pattern = 7'h6D;
      4'h3: pattern = 7'h79;
      4'h4: pattern = 7'h33;
      4'h5: pattern = 7'h5B;
      4'h6: pattern = 7'h5F;
      4'h7: pattern = 7'h70;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h7B;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h1F;
      4'hC: pattern = 7'h4E;
      4'hD: pattern = 7'h3D;
      4'hE: pattern = 7'h4F;
      default: pattern = 7'h47;
    endcase
  end

  // Output drive: one-hot-low anode only in ACTIVE on an unblanked digit.
  always_comb begin
    an_out  = 8'hFF;
    seg_out = 8'hFF;
    if (state_q == S_ACTIVE && !blank_q[idx_q]) begin
      an_out  = ~(8'd1 << idx_q);
      seg_out = ~{pattern, cur_digit[4]};
    end
    digit_idx  = idx_q;
    frame_tick = tick_q;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (DIV=4, DEAD=2). The reference model tracks
// only "how many cycles since the scan started" and derives slot, phase and
// frame boundaries from that by division.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIV + DEAD;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n, en, wr_en;
  logic [2:0] wr_idx;
  logic [4:0] wr_data;
  logic [7:0] blank;
  logic [7:0] seg_out, an_out;
  logic [2:0] digit_idx;
  logic       frame_tick;

  int ncmp = 0;
  int nerr = 0;

  // Reference model state
  bit         m_run;
  int         m_p;
  logic [4:0] m_dig [8];
  logic [7:0] m_blank;
  int         tick_seen;

  logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .blank(blank), .seg_out(seg_out), .an_out(an_out),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int m_slot();
    return (m_p / SLOT) % 8;
  endfunction

  function automatic int m_off();
    return m_p % SLOT;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_run = 1'b0;
      m_p   = 0;
      m_blank = 8'h00;
      for (int i = 0; i < 8; i++) m_dig[i] = 5'h00;
    end else begin
      m_blank = blank;
      if (wr_en) m_dig[wr_idx] = wr_data;
      if (!en) begin
        m_run = 1'b0;
        m_p   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_p   = 0;
      end else begin
        m_p++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_an, e_seg;
    logic [2:0] e_idx;
    logic       e_tick;
    int         s;
    s      = m_slot();
    e_an   = 8'hFF;
    e_seg  = 8'hFF;
    e_idx  = m_run ? 3'(s) : 3'd0;
    e_tick = m_run && (m_p > 0) && (m_p % FRAME == 0);
    if (m_run && m_off() < DIV && !m_blank[s]) begin
      e_an  = ~(8'd1 << s);
      e_seg = ~{pat_tab[m_dig[s][3:0]], m_dig[s][4]};
    end
    ncmp += 4;
    assert (an_out === e_an) else begin
      nerr++; $error("FAIL an_out t=%0t got %h exp %h", $time, an_out, e_an);
    end
    assert (seg_out === e_seg) else begin
      nerr++; $error("FAIL seg_out t=%0t got %h exp %h", $time, seg_out, e_seg);
    end
    assert (digit_idx === e_idx) else begin
      nerr++; $error("FAIL digit_idx t=%0t got %0d exp %0d", $time, digit_idx, e_idx);
    end
    assert (frame_tick === e_tick) else begin
      nerr++; $error("FAIL frame_tick t=%0t got %b exp %b", $time, frame_tick, e_tick);
    end
    if (frame_tick === 1'b1) tick_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the model sits at the requested slot/phase; bounded.
  task automatic wait_phase(input int s, input int o, input string tag);
    int k;
    k = 0;
    while (!(m_run && m_slot() == s && m_off() == o) && k < 200) begin
      step();
      k++;
    end
    ncmp++;
    assert (k < 200) else begin
      nerr++; $error("FAIL wait_%s timeout got %0d cycles exp <200", tag, k);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 5'd0; blank = 8'h00;
    m_run = 1'b0; m_p = 0; m_blank = 8'h00; tick_seen = 0;
    for (int i = 0; i < 8; i++) m_dig[i] = 5'h00;
    #2;
    run(3);
    rst_n = 1'b1;

    // Load digits 0..7 with their own index, dp clear.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_idx = 3'(i); wr_data = 5'(i);
      step();
    end
    wr_en = 1'b0;

    // Start scanning and cover a full frame plus a bit.
    en = 1'b1;
    tick_seen = 0;
    run(FRAME + 12);
    ncmp++;
    assert (tick_seen === 1) else begin
      nerr++; $error("FAIL frame_count got %0d exp 1", tick_seen);
    end

    // Rewrite the digit on display while it is lit.
    wait_phase(0, 1, "slot0");
    wr_en = 1'b1; wr_idx = 3'd0; wr_data = 5'h1A;
    step();
    wr_en = 1'b0;
    run(4);

    // Blank digit 1 for two frames.
    blank = 8'h02;
    run(2 * FRAME);
    blank = 8'h00;

    // Drop en in the middle of slot 3, then restart.
    wait_phase(3, 1, "slot3");
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(SLOT * 3);

    // Reset during DEAD with a simultaneous write.
    wait_phase(2, DIV, "dead2");
    rst_n = 1'b0; wr_en = 1'b1; wr_idx = 3'd2; wr_data = 5'h1F;
    step();
    rst_n = 1'b1; wr_en = 1'b0;
    run(SLOT * 2);

    // Randomized traffic.
    for (int k = 0; k < 900; k++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      en      = ($urandom_range(0, 59) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) blank = 8'($urandom_range(0, 255));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
